// File: rtl/secure_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// secure_reg_access_arbiter
//
// Front-end for the thread-gated secure register. A round-robin arbiter
// accepts one transaction at a time from NUM_REQ requesters. Only thread 0
// may reach the register; every other thread gets an error response and
// bumps a saturating violation counter.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   req_valid      : per-requester request valid
//   req_ready      : per-requester accept strobe (IDLE only, one-hot)
//   req_we         : per-requester write (1) / read (0)
//   req_tid        : per-requester thread id, packed TID_WIDTH per requester
//   req_wdata      : per-requester write data, packed DATA_WIDTH per requester
//   rsp_valid      : one-hot response pulse to the granted requester
//   rsp_rdata      : read data (0 for writes, errors and idle cycles)
//   rsp_err        : access denied (0 when no response)
//   reg_access_en  : register access strobe
//   reg_wr_en      : register write enable
//   reg_thread_id  : thread id to the register
//   reg_data_in    : write data to the register
//   reg_data_out   : register read data, valid one cycle after reg_access_en
//   viol_clr       : clears violation count and sticky flag
//   viol_count     : saturating violation count
//   viol_sticky    : set by any violation
// ---------------------------------------------------------------------------
module secure_reg_access_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int TID_WIDTH      = 2,
    parameter int VIOL_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*TID_WIDTH-1:0]  req_tid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          reg_access_en,
    output logic                          reg_wr_en,
    output logic [TID_WIDTH-1:0]          reg_thread_id,
    output logic [DATA_WIDTH-1:0]         reg_data_in,
    input  logic [DATA_WIDTH-1:0]         reg_data_out,
    input  logic                          viol_clr,
    output logic [VIOL_CNT_WIDTH-1:0]     viol_count,
    output logic                          viol_sticky
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so last_grant + offset never overflows before the wrap.
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    function automatic logic [VIOL_CNT_WIDTH-1:0] sat_inc(input logic [VIOL_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] o;
        o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o[i] = (idx == IDX_W'(i));
        end
        return o;
    endfunction

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            last_grant_q, last_grant_d;
    logic [IDX_W-1:0]            sel_q, sel_d;
    logic                        we_q, we_d;
    logic [TID_WIDTH-1:0]        tid_q, tid_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic [VIOL_CNT_WIDTH-1:0]   viol_count_q, viol_count_d;
    logic                        viol_sticky_q, viol_sticky_d;
    logic                        viol_inc;

    logic                        arb_found;
    logic [IDX_W-1:0]            arb_idx;
    logic [SUM_W-1:0]            arb_sum;
    logic [IDX_W-1:0]            arb_cand;

    // Round-robin pick: first valid index after last_grant, wrapping at
    // NUM_REQ-1, so the most recently served requester is checked last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        arb_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_sum = {1'b0, last_grant_q} + SUM_W'(k);
            if (arb_sum >= SUM_W'(NUM_REQ)) begin
                arb_sum = arb_sum - SUM_W'(NUM_REQ);
            end
            arb_cand = arb_sum[IDX_W-1:0];
            if (!arb_found && req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        sel_d         = sel_q;
        we_d          = we_q;
        tid_d         = tid_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        viol_inc      = 1'b0;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        reg_access_en = 1'b0;
        reg_wr_en     = 1'b0;
        reg_thread_id = '0;
        reg_data_in   = '0;

        case (state_q)
            IDLE: begin
                // ready is only raised for the selected requester, whose valid
                // is known to be high, so ready alone implies the handshake.
                if (arb_found) begin
                    req_ready = onehot(arb_idx);
                    sel_d     = arb_idx;
                    we_d      = req_we[arb_idx];
                    tid_d     = req_tid[arb_idx*TID_WIDTH +: TID_WIDTH];
                    wdata_d   = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (tid_q == '0) begin
                    reg_access_en = 1'b1;
                    reg_wr_en     = we_q;
                    reg_thread_id = tid_q;
                    reg_data_in   = wdata_q;
                    state_d       = CAPTURE;
                end else begin
                    // Denied threads never touch the register port.
                    err_d    = 1'b1;
                    viol_inc = 1'b1;
                    state_d  = RESP;
                end
            end
            CAPTURE: begin
                rdata_d = reg_data_out;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid    = onehot(sel_q);
                rsp_err      = err_q;
                rsp_rdata    = (!err_q && !we_q) ? rdata_q : '0;
                last_grant_d = sel_q;
                err_d        = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A clear coinciding with a violation keeps that violation.
    always_comb begin
        viol_count_d  = viol_count_q;
        viol_sticky_d = viol_sticky_q;
        if (viol_clr) begin
            viol_count_d  = viol_inc ? VIOL_CNT_WIDTH'(1) : '0;
            viol_sticky_d = viol_inc;
        end else if (viol_inc) begin
            viol_count_d  = sat_inc(viol_count_q);
            viol_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            sel_q         <= '0;
            we_q          <= 1'b0;
            tid_q         <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            viol_count_q  <= '0;
            viol_sticky_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            tid_q         <= tid_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            viol_count_q  <= viol_count_d;
            viol_sticky_q <= viol_sticky_d;
        end
    end

    assign viol_count  = viol_count_q;
    assign viol_sticky = viol_sticky_q;

endmodule

// File: tb/tb_secure_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_secure_reg_access_arbiter
//
// Self-checking bench for secure_reg_access_arbiter (NUM_REQ = 4,
// VIOL_CNT_WIDTH = 2). A small behavioural secure-register model sits on the
// register port; a transaction-level reference model predicts grants,
// responses and violation status.
// ---------------------------------------------------------------------------
module tb_secure_reg_access_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TW = 2;
    localparam int VW = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*TW-1:0]  req_tid;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              reg_access_en;
    logic              reg_wr_en;
    logic [TW-1:0]     reg_thread_id;
    logic [DW-1:0]     reg_data_in;
    logic [DW-1:0]     reg_data_out;
    logic              viol_clr;
    logic [VW-1:0]     viol_count;
    logic              viol_sticky;

    secure_reg_access_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .TID_WIDTH(TW), .VIOL_CNT_WIDTH(VW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_tid(req_tid), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .reg_access_en(reg_access_en), .reg_wr_en(reg_wr_en),
        .reg_thread_id(reg_thread_id), .reg_data_in(reg_data_in),
        .reg_data_out(reg_data_out),
        .viol_clr(viol_clr), .viol_count(viol_count), .viol_sticky(viol_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Secure register: stores on write, returns the stored value one cycle
    // after a read access (write data is echoed so a leak would be visible).
    logic [DW-1:0] sreg_mem;
    initial begin
        sreg_mem     = '0;
        reg_data_out = '0;
    end
    always @(posedge clk) begin
        if (reg_access_en && reg_thread_id == '0) begin
            if (reg_wr_en) sreg_mem <= reg_data_in;
            reg_data_out <= reg_wr_en ? reg_data_in : sreg_mem;
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            model_last;
    int            model_viol;
    bit            model_sticky;
    logic [DW-1:0] model_mem = '0;

    function automatic int rr_pick(input logic [NR-1:0] mask, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (mask[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Transaction observations
    int            o_tacc, o_nacc, o_trsp;
    bit            o_we, o_err, o_leak, o_hs;
    logic [DW-1:0] o_din, o_rdata;
    logic [TW-1:0] o_tid;
    logic [NR-1:0] o_rspv;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; viol_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = NR - 1; model_viol = 0; model_sticky = 0;
    endtask

    // Drives one request from requester r and records what the DUT does in
    // the cycles after the handshake (cycle index 1 = cycle after handshake).
    task automatic issue_one(input int r, input bit w, input logic [TW-1:0] t,
                             input logic [DW-1:0] d, input int clr_at);
        o_tacc = 0; o_nacc = 0; o_trsp = 0; o_we = 0; o_err = 0; o_leak = 0;
        o_hs = 0; o_din = '0; o_rdata = '0; o_tid = '0; o_rspv = '0;
        @(negedge clk);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_we[r] = w;
        req_tid[r*TW +: TW] = t;
        req_wdata[r*DW +: DW] = d;
        for (int i = 0; i < 20 && !o_hs; i++) begin
            #1;
            if (req_ready[r]) o_hs = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid = '0;
        if (o_hs) begin
            for (int c = 1; c <= 8 && o_trsp == 0; c++) begin
                viol_clr = (c == clr_at);
                #1;
                if (reg_access_en) begin
                    o_nacc++; o_tacc = c; o_we = reg_wr_en; o_din = reg_data_in; o_tid = reg_thread_id;
                end else if (reg_wr_en || reg_data_in != '0 || reg_thread_id != '0) o_leak = 1;
                if (rsp_valid != '0) begin
                    o_trsp = c; o_rspv = rsp_valid; o_rdata = rsp_rdata; o_err = rsp_err;
                end else if (rsp_rdata != '0 || rsp_err) o_leak = 1;
                @(negedge clk);
            end
        end
        viol_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_we = '0; req_tid = '0; req_wdata = '0; viol_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_last = NR - 1; model_viol = 0; model_sticky = 0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, reg_access_en, reg_wr_en, reg_thread_id, reg_data_in} !== '0)
            begin errors++; $display("FAIL reset_outputs: got nonzero outputs, required all zero"); end
        checks++;
        if (viol_count !== '0 || viol_sticky !== 1'b0)
            begin errors++; $display("FAIL reset_viol: got count=%0d sticky=%0b, required 0/0", viol_count, viol_sticky); end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001)
            begin errors++; $display("FAIL reset_first_grant: got ready=%b, required 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_write_read();
        issue_one(1, 1'b1, 2'd0, 32'hDEADBEEF, 0);
        checks++;
        if (!o_hs || o_tacc != 1 || o_nacc != 1 || o_we !== 1'b1 || o_din !== 32'hDEADBEEF)
            begin errors++; $display("FAIL wr_access: got hs=%0b tacc=%0d n=%0d we=%0b din=%h, required 1/1/1/1/deadbeef", o_hs, o_tacc, o_nacc, o_we, o_din); end
        checks++;
        if (o_trsp != 3 || o_rspv !== 4'b0010 || o_err !== 1'b0 || o_rdata !== '0)
            begin errors++; $display("FAIL wr_resp: got t=%0d v=%b err=%0b rd=%h, required 3/0010/0/0", o_trsp, o_rspv, o_err, o_rdata); end
        model_mem = 32'hDEADBEEF; model_last = 1;
        issue_one(1, 1'b0, 2'd0, 32'h0, 0);
        checks++;
        if (o_trsp != 3 || o_rspv !== 4'b0010 || o_err !== 1'b0 || o_rdata !== model_mem || o_we !== 1'b0)
            begin errors++; $display("FAIL rd_resp: got t=%0d v=%b err=%0b rd=%h, required 3/0010/0/%h", o_trsp, o_rspv, o_err, o_rdata, model_mem); end
        checks++;
        if (o_leak) begin errors++; $display("FAIL wr_rd_idle_outputs: got nonzero outputs outside ISSUE/RESP, required zero"); end
    endtask

    task automatic test_denied();
        issue_one(2, 1'b1, 2'd3, 32'h12345678, 0);
        model_viol = (model_viol < 3) ? model_viol + 1 : 3; model_sticky = 1; model_last = 2;
        checks++;
        if (!o_hs || o_nacc != 0 || o_leak)
            begin errors++; $display("FAIL denied_no_access: got hs=%0b n=%0d leak=%0b, required 1/0/0", o_hs, o_nacc, o_leak); end
        checks++;
        if (o_trsp != 2 || o_rspv !== 4'b0100 || o_err !== 1'b1 || o_rdata !== '0)
            begin errors++; $display("FAIL denied_resp: got t=%0d v=%b err=%0b rd=%h, required 2/0100/1/0", o_trsp, o_rspv, o_err, o_rdata); end
        checks++;
        if (viol_count !== VW'(model_viol) || viol_sticky !== model_sticky)
            begin errors++; $display("FAIL denied_viol: got count=%0d sticky=%0b, required %0d/%0b", viol_count, viol_sticky, model_viol, model_sticky); end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 5; n++) begin
            int r;
            r = $urandom_range(0, NR - 1);
            issue_one(r, $urandom_range(0, 1), TW'($urandom_range(1, 3)), $urandom, 0);
            model_viol = (model_viol < 3) ? model_viol + 1 : 3; model_sticky = 1; model_last = r;
            checks++;
            if (viol_count !== VW'(model_viol) || o_err !== 1'b1 || o_rspv !== NR'(1 << r))
                begin errors++; $display("FAIL sat_step%0d: got count=%0d err=%0b v=%b, required %0d/1/%b", n, viol_count, o_err, o_rspv, model_viol, NR'(1 << r)); end
        end
        @(negedge clk); viol_clr = 1'b1;
        @(negedge clk); viol_clr = 1'b0;
        #1;
        checks++;
        if (viol_count !== '0 || viol_sticky !== 1'b0)
            begin errors++; $display("FAIL clr_alone: got count=%0d sticky=%0b, required 0/0", viol_count, viol_sticky); end
        issue_one(3, 1'b0, 2'd1, 32'h0, 1);
        model_viol = 1; model_sticky = 1; model_last = 3;
        checks++;
        if (viol_count !== VW'(1) || viol_sticky !== 1'b1 || o_trsp != 2)
            begin errors++; $display("FAIL clr_with_viol: got count=%0d sticky=%0b t=%0d, required 1/1/2", viol_count, viol_sticky, o_trsp); end
    endtask

    task automatic test_round_robin();
        int grants, last_cyc;
        apply_reset();
        grants = 0; last_cyc = -1;
        @(negedge clk);
        req_valid = '1; req_we = '0; req_tid = '0;
        for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
            #1;
            if (req_ready != '0) begin
                int exp;
                exp = rr_pick(req_valid, model_last);
                checks++;
                if (req_ready !== NR'(1 << exp))
                    begin errors++; $display("FAIL rr_grant%0d: got ready=%b, required %b", grants, req_ready, NR'(1 << exp)); end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != 4)
                        begin errors++; $display("FAIL rr_spacing%0d: got %0d cycles, required 4", grants, cyc - last_cyc); end
                end
                model_last = exp; last_cyc = cyc; grants++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        checks++;
        if (grants != 5) begin errors++; $display("FAIL rr_count: got %0d grants, required 5", grants); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_rr_random();
        for (int n = 0; n < 12; n++) begin
            logic [NR-1:0] mask;
            bit seen;
            int exp;
            seen = 0;
            mask = NR'($urandom_range(1, 15));
            exp = rr_pick(mask, model_last);
            @(negedge clk);
            req_valid = mask; req_we = '0; req_tid = '0;
            for (int i = 0; i < 10 && !seen; i++) begin
                #1;
                if (req_ready != '0) seen = 1;
                else @(negedge clk);
            end
            checks++;
            if (!seen || req_ready !== NR'(1 << exp))
                begin errors++; $display("FAIL rrr_grant%0d: got ready=%b mask=%b, required %b", n, req_ready, mask, NR'(1 << exp)); end
            model_last = exp;
            @(negedge clk);
            req_valid = '0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        bit seen, any_rsp;
        seen = 0; any_rsp = 0;
        @(negedge clk);
        req_valid = 4'b0100; req_we[2] = 1'b0; req_tid[2*TW +: TW] = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (req_ready[2]) seen = 1;
            else @(negedge clk);
        end
        @(negedge clk); req_valid = '0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_last = NR - 1; model_viol = 0; model_sticky = 0;
        #1;
        checks++;
        if (!seen || {req_ready, rsp_valid, rsp_rdata, rsp_err, reg_access_en, reg_wr_en, reg_thread_id, reg_data_in, viol_count, viol_sticky} !== '0)
            begin errors++; $display("FAIL midop_outputs: got hs=%0b rsp_valid=%b access=%0b count=%0d, required 1 and all zero", seen, rsp_valid, reg_access_en, viol_count); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (rsp_valid != '0) any_rsp = 1;
        end
        checks++;
        if (any_rsp) begin errors++; $display("FAIL midop_no_rsp: got a response after reset, required none"); end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001)
            begin errors++; $display("FAIL midop_next_grant: got ready=%b, required 0001", req_ready); end
        model_last = 0;
        @(negedge clk); req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int r;
            bit w, ok;
            logic [TW-1:0] t;
            logic [DW-1:0] d, exp_rd;
            r = $urandom_range(0, NR - 1);
            w = $urandom_range(0, 1);
            t = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(1, 3)) : '0;
            d = $urandom;
            ok = (t == '0);
            exp_rd = (ok && !w) ? model_mem : '0;
            issue_one(r, w, t, d, 0);
            checks++;
            if (!o_hs || o_trsp != (ok ? 3 : 2) || o_rspv !== NR'(1 << r) || o_err !== !ok || o_rdata !== exp_rd)
                begin errors++; $display("FAIL rand%0d_resp: got hs=%0b t=%0d v=%b err=%0b rd=%h, required 1/%0d/%b/%0b/%h", n, o_hs, o_trsp, o_rspv, o_err, o_rdata, ok ? 3 : 2, NR'(1 << r), !ok, exp_rd); end
            checks++;
            if (o_nacc != (ok ? 1 : 0) || o_leak || (ok && (o_tacc != 1 || o_we !== w || o_din !== d || o_tid !== '0)))
                begin errors++; $display("FAIL rand%0d_access: got n=%0d t=%0d we=%0b din=%h leak=%0b, required %0d/1/%0b/%h/0", n, o_nacc, o_tacc, o_we, o_din, o_leak, ok ? 1 : 0, w, d); end
            if (ok && w) model_mem = d;
            if (!ok) begin model_viol = (model_viol < 3) ? model_viol + 1 : 3; model_sticky = 1; end
            model_last = r;
            checks++;
            if (viol_count !== VW'(model_viol) || viol_sticky !== model_sticky)
                begin errors++; $display("FAIL rand%0d_viol: got count=%0d sticky=%0b, required %0d/%0b", n, viol_count, viol_sticky, model_viol, model_sticky); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_denied();
        test_saturation();
        test_round_robin();
        test_rr_random();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/secure_reg_access_arbiter.md
Name: secure_reg_access_arbiter

Overview:
- Upstream front-end for the thread-gated secure register.
- Arbitrates round-robin among NUM_REQ requesters and forwards only thread_id == 0 transactions to the register port.
- Returns read data or an error response to the granted requester, and counts access violations.
- Sits between the multi-thread bus fabric and the secure register's clk/data_in/wr_en/access_en/thread_id/data_out interface.

Parameters:
- DATA_WIDTH, 32, register data width.
- NUM_REQ, 4, number of requesters (2..8).
- TID_WIDTH, 2, thread id width.
- VIOL_CNT_WIDTH, 8, violation counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept strobe.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_tid  input  NUM_REQ*TID_WIDTH  thread id; requester i at [i*TID_WIDTH +: TID_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  output  NUM_REQ  one-hot response pulse.
- rsp_rdata  output  DATA_WIDTH  read data.
- rsp_err  output  1  access denied.
- reg_access_en  output  1  register access enable.
- reg_wr_en  output  1  register write enable.
- reg_thread_id  output  TID_WIDTH  thread id to register.
- reg_data_in  output  DATA_WIDTH  write data to register.
- reg_data_out  input  DATA_WIDTH  register read data; valid one cycle after reg_access_en.
- viol_clr  input  1  clear violation status.
- viol_count  output  VIOL_CNT_WIDTH  saturating violation count.
- viol_sticky  output  1  set on any violation.

Behaviour:
- Reset: state = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first; all outputs, latches, viol_count and viol_sticky = 0.
- Reset mid-transaction aborts it. No rsp_valid is issued and no register access completes after reset is sampled.

FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any req_valid, select the first set index searching from last_grant+1 with wrap at NUM_REQ-1 -> 0.
  - req_ready[sel] = 1 combinationally in this cycle only.
  - Handshake = valid & ready. On handshake, latch sel, we, tid and wdata, then go to ISSUE.
  - req_ready is 0 in all other states. Requesters hold valid and payload stable until ready.
- ISSUE, latched tid == 0: one-cycle pulse reg_access_en = 1, reg_wr_en = latched we, reg_thread_id = tid, reg_data_in = wdata. Go to CAPTURE.
- ISSUE, latched tid != 0: all reg_* outputs stay 0. Set err, increment the violation counter, go to RESP.
- CAPTURE: latch reg_data_out, go to RESP.
- RESP: rsp_valid[sel] = 1 for exactly one cycle. Drive rsp_err = err.
  - rsp_rdata = captured data for a permitted read; 0 for writes and errors.
  - Set last_grant = sel, clear err, go to IDLE.
- rsp_rdata and rsp_err are 0 whenever rsp_valid == 0.
- reg_* outputs are 0 outside ISSUE.

Latency (handshake in cycle T):
- Permitted access: reg_access_en at T+1, rsp_valid at T+3.
- Denied access: rsp_valid at T+2.
- Next handshake no earlier than the cycle after RESP.
- Maximum throughput: one transaction per 4 cycles.

Fairness:
- The requester just served has lowest priority next round.
- A continuously asserting requester is served within NUM_REQ transactions.

Violation tracking:
- viol_count saturates at 2^VIOL_CNT_WIDTH-1 with no wrap.
- viol_sticky is set on every violation.
- viol_clr zeroes both. If viol_clr coincides with a violation increment, the result is viol_count = 1 and viol_sticky = 1.

Test Plan:
- Write then read, tid 0: requester 1 writes 0xDEADBEEF; reg_access_en = 1 and reg_wr_en = 1 one cycle after the handshake; rsp_valid = 0b0010 at T+3 with rsp_err = 0. A subsequent read returns rsp_rdata = 0xDEADBEEF.
- Denied access: requester 2 writes with tid = 3 -> no reg_access_en; rsp_valid = 0b0100 at T+2, rsp_err = 1, rsp_rdata = 0; viol_count 0 -> 1; viol_sticky = 1.
- Round-robin: all four req_valid held high with tid = 0 -> grants in order 0, 1, 2, 3, 0. req_ready is one-hot and asserted only in IDLE.
- Saturation and clear: with VIOL_CNT_WIDTH = 2, issue 5 denied requests -> viol_count = 3. Pulse viol_clr alone -> 0. Pulse viol_clr in the same cycle as a violation -> viol_count = 1.
- Reset mid-op: assert rst in the CAPTURE cycle -> no rsp_valid; all outputs 0 the next cycle; the next grant goes to requester 0.
